// File: rtl/gen_pkg.sv
// Shared generator definitions: Q-format constants, output geometry, collector FSM states and
// the tanh-to-pixel conversion.
package gen_pkg;

  localparam int unsigned FRAC_BITS = 8;
  localparam int unsigned ONE       = 1 << FRAC_BITS;
  localparam int unsigned IMG_W     = 28;
  localparam int unsigned IMG_H     = 28;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  // Shift [-1.0, 1.0) up to [0, 2.0), rescale to pix_width bits and clamp. The caller keeps the
  // low pix_width bits of the result.
  function automatic logic signed [32:0] tanh_to_pixel(input logic signed [31:0] sample,
                                                       input int unsigned frac_bits,
                                                       input int unsigned pix_width);
    logic signed [32:0] s;
    logic signed [32:0] p;
    logic signed [32:0] pmax;
    s    = $signed({sample[31], sample}) + (33'sd1 <<< frac_bits);
    p    = s >>> (frac_bits + 1 - pix_width);
    pmax = (33'sd1 <<< pix_width) - 33'sd1;
    if (p < 33'sd0) return '0;
    if (p > pmax) return pmax;
    return p;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port (1-cycle latency).
module frame_ram #(
  parameter int unsigned DEPTH = 784,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 10
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/gen_frame_collector.sv
// Captures one raster-ordered generator frame (no backpressure), converts samples to pixels,
// buffers it and drains it over a ready/valid stream.
module gen_frame_collector #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = gen_pkg::FRAC_BITS,
  parameter int unsigned PIX_WIDTH  = 8,
  parameter int unsigned IMG_W      = gen_pkg::IMG_W,
  parameter int unsigned IMG_H      = gen_pkg::IMG_H
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic        [PIX_WIDTH-1:0]  m_data,
  output logic                         m_last,
  output logic                         frame_done,
  output logic                         overflow,
  input  logic                         clr_overflow,
  output logic                         busy
);

  import gen_pkg::*;

  localparam int unsigned FRAME = IMG_W * IMG_H;
  localparam int unsigned CW    = $clog2(FRAME + 1);
  localparam int unsigned AW    = (FRAME > 1) ? $clog2(FRAME) : 1;

  state_e                 r_state, w_state_d;
  logic [CW-1:0]          r_wr_cnt, w_wr_cnt_d;
  logic [CW-1:0]          r_rd_cnt, w_rd_cnt_d;
  logic                   w_we;
  logic [AW-1:0]          w_waddr;
  logic [PIX_WIDTH-1:0]   w_pix;
  logic [PIX_WIDTH-1:0]   w_rdata;
  logic                   w_rd_en;
  logic                   w_hs;
  logic                   w_frame_done_d;
  logic                   w_ovf_set;
  logic                   r_rd_pend;
  logic                   r_pend_last;
  logic                   r_m_valid;
  logic [PIX_WIDTH-1:0]   r_m_data;
  logic                   r_m_last;
  logic                   r_frame_done;
  logic                   r_overflow;

  assign w_pix = PIX_WIDTH'(tanh_to_pixel(32'(data_in), FRAC_BITS, PIX_WIDTH));
  assign w_hs  = r_m_valid & m_ready;

  // Read only when the output register is guaranteed free on the cycle the data lands.
  assign w_rd_en = (r_state == DRAIN) && (r_rd_cnt < CW'(FRAME)) && !r_rd_pend &&
                   (!r_m_valid || w_hs);

  always_comb begin
    w_state_d      = r_state;
    w_wr_cnt_d     = r_wr_cnt;
    w_rd_cnt_d     = r_rd_cnt;
    w_we           = 1'b0;
    w_waddr        = r_wr_cnt[AW-1:0];
    w_frame_done_d = 1'b0;
    w_ovf_set      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (valid_in) begin
          w_we       = 1'b1;
          w_waddr    = '0;
          w_wr_cnt_d = CW'(1);
          if (FRAME == 1) begin
            w_state_d      = DRAIN;
            w_frame_done_d = 1'b1;
          end else begin
            w_state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (valid_in) begin
          w_we       = 1'b1;
          w_wr_cnt_d = r_wr_cnt + CW'(1);
          if (r_wr_cnt == CW'(FRAME - 1)) begin
            w_state_d      = DRAIN;
            w_frame_done_d = 1'b1;
            w_rd_cnt_d     = '0;
          end
        end
      end
      DRAIN: begin
        w_ovf_set = valid_in;
        if (w_rd_en) w_rd_cnt_d = r_rd_cnt + CW'(1);
        if (w_hs && r_m_last) begin
          w_state_d  = IDLE;
          w_wr_cnt_d = '0;
          w_rd_cnt_d = '0;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_rd_pend    <= 1'b0;
      r_pend_last  <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_last     <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_wr_cnt     <= w_wr_cnt_d;
      r_rd_cnt     <= w_rd_cnt_d;
      r_frame_done <= w_frame_done_d;
      r_rd_pend    <= w_rd_en;
      if (w_rd_en) r_pend_last <= (r_rd_cnt == CW'(FRAME - 1));
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
      // A pending read only exists while the output register is empty.
      if (r_rd_pend) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_rdata;
        r_m_last  <= r_pend_last;
      end else if (w_hs) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end
    end
  end

  frame_ram #(
    .DEPTH (FRAME),
    .WIDTH (PIX_WIDTH),
    .AW    (AW)
  ) u_frame_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_pix),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_cnt[AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;
  assign busy       = (r_state != IDLE);

endmodule

// File: doc/gen_frame_collector.md
Name: gen_frame_collector

Overview:
- Sits directly downstream of the generator's final tanh activation.
- Captures the raster-ordered 28x28 output stream, which has no backpressure, and converts each Q-format tanh sample to an unsigned pixel.
- Stores one full frame in on-chip RAM, then drains it over a ready/valid stream toward the host/UART/DMA side.
- Reports frame completion and any overrun.

Parameters:
- DATA_WIDTH, 16: width of the signed generator sample.
- FRAC_BITS, 8: fractional bits of the sample; 1.0 = 2^FRAC_BITS.
- PIX_WIDTH, 8: output pixel width, unsigned.
- IMG_W, 28: pixels per row.
- IMG_H, 28: rows per frame.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- valid_in  in  1  generator sample strobe (no backpressure)
- data_in  in  DATA_WIDTH  signed tanh sample
- m_valid  out  1  drain stream valid
- m_ready  in  1  drain stream ready
- m_data  out  PIX_WIDTH  pixel
- m_last  out  1  high with the final pixel of the frame
- frame_done  out  1  one-cycle pulse when capture completes
- overflow  out  1  sticky; sample arrived while not accepting
- clr_overflow  in  1  synchronous clear of overflow
- busy  out  1  high when state != IDLE

Behaviour:
- Reset values: m_valid=0, m_data=0, m_last=0, frame_done=0, overflow=0, busy=0, state=IDLE, all counters 0. RAM contents are undefined.
- Reset asserted mid-frame aborts capture or drain immediately. A partial frame is discarded.
- Pixel conversion (combinational, ahead of the RAM write):
  - s = data_in + 2^FRAC_BITS, computed at DATA_WIDTH+1 bits signed.
  - p = s >>> (FRAC_BITS+1-PIX_WIDTH).
  - If p < 0 the pixel is 0. If p > 2^PIX_WIDTH-1 the pixel is 2^PIX_WIDTH-1. Otherwise the pixel is p.
  - With defaults: -256→0, 0→128, 255→255, 256→255 (saturated), -32768→0.
- FRAME = IMG_W*IMG_H (784). RAM is single-port-write / single-port-read, depth FRAME, width PIX_WIDTH, synchronous read with 1-cycle latency.
- States:
  - IDLE:
    - valid_in writes pixel at addr 0, wr_cnt becomes 1, go CAPTURE.
    - If FRAME==1, go DRAIN and pulse frame_done.
  - CAPTURE:
    - Each valid_in writes at wr_cnt and increments wr_cnt.
    - The write at wr_cnt==FRAME-1 pulses frame_done the next cycle and moves to DRAIN with rd_cnt=0.
  - DRAIN:
    - Streams addresses 0..FRAME-1 in order.
    - Any valid_in here sets overflow and the sample is dropped; RAM is not modified.
    - Leaves to IDLE the cycle after the handshake (m_valid&m_ready) on the m_last beat.
- Drain pipeline:
  - One output register plus a read-pending flag.
  - A RAM read is issued when rd_cnt<FRAME and the output register will be free next cycle: either !m_valid, or m_valid&m_ready, with no read already pending.
  - The read data loads m_data and sets m_valid. m_last=1 when the loaded address is FRAME-1.
  - m_valid/m_data/m_last hold stable while m_valid&!m_ready.
  - With m_ready held high, throughput is 1 pixel every 2 cycles minimum. The first m_valid appears 2 cycles after entering DRAIN.
- Overflow and clear: clr_overflow and a new overflow event in the same cycle leave overflow=1 (set wins).
- Return to IDLE and back-to-back frames: a valid_in in the cycle the state returns to IDLE starts the next frame normally. A valid_in on the same cycle as the final handshake is an overflow.
- Counters: wr_cnt/rd_cnt are $clog2(FRAME+1) bits and never wrap; they are reset to 0 on entering IDLE.

Decomposition:
- Shared package (gen_pkg) holds:
  - Q-format constants FRAC_BITS and ONE=2^FRAC_BITS.
  - Generator output geometry IMG_W=28, IMG_H=28.
  - The FSM state enum, 2-bit: IDLE, CAPTURE, DRAIN.
- One natural sub-module: frame_ram, a simple dual-port synchronous RAM (write port, registered read port) parameterised by depth/width.
- Pixel saturation stays inline as a function in the package (tanh_to_pixel).

Test Plan:
- Conversion sweep:
  - Stimulus: 784 samples cycling {-32768,-257,-256,-1,0,1,255,256,32767}, m_ready=1.
  - Required pixels in the same order: {0,0,0,127,128,128,255,255,255}.
  - m_last on beat 784 only; frame_done exactly one pulse, 1 cycle after the 784th valid_in.
- Sparse input:
  - Stimulus: valid_in 1-in-3 cycles for a full frame.
  - Required: all 784 pixels drained in order; no overflow.
- Backpressure:
  - Stimulus: m_ready random 30% high during drain.
  - Required: m_data/m_last stable while stalled; exactly 784 handshakes; busy falls 1 cycle after the last handshake.
- Overrun:
  - Stimulus: 5 extra valid_in during DRAIN with data 0.
  - Required: overflow=1, drained frame unchanged.
  - clr_overflow → 0 next cycle; clr_overflow coincident with a new overrun → remains 1.
- Reset mid-capture:
  - Stimulus: rst_n low after 400 samples, then a fresh 784-sample frame.
  - Required: all outputs return to reset values asynchronously; only the new frame is drained; frame_done pulses once.
- Back-to-back frames:
  - Stimulus: second frame's first valid_in in the first IDLE cycle after the m_last handshake.
  - Required: second frame captured completely, no overflow.
